dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_pkg.sv | 17 +
 rtl/rr_arb2.sv | 32 +++
 rtl/dmem_arbiter.sv | 114 +++++++++++
 tb/tb_dmem_arbiter.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM states, port indices
// and default widths.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic PORT_CORE = 1'b0;
  localparam logic PORT_DMA  = 1'b1;

  localparam int DEFAULT_DM_ADDRESS = 9;
  localparam int DEFAULT_DATA_W     = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter: combinational pick, plus a register holding
// the last port granted so that ties alternate.
module rr_arb2
  import dmem_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       update,
  output logic       pick
);

  logic last;

  always_comb begin
    pick = PORT_CORE;
    case (req)
      2'b10:   pick = PORT_DMA;
      2'b11:   pick = ~last;
      default: pick = PORT_CORE;
    endcase
  end

  // Starting at PORT_DMA hands the first tie to the core port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      last <= PORT_DMA;
    else if (update)
      last <= pick;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Arbitrates the core and DMA/debug ports onto one data memory; each access
// takes three cycles (IDLE sample, ACCESS drive, RESP acknowledge).
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DM_ADDRESS = DEFAULT_DM_ADDRESS,
  parameter int DATA_W     = DEFAULT_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [DM_ADDRESS-1:0] p0_addr,
  input  logic [DATA_W-1:0]     p0_wdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [DM_ADDRESS-1:0] p1_addr,
  input  logic [DATA_W-1:0]     p1_wdata,
  output logic                  p0_gnt,
  output logic                  p1_gnt,
  output logic                  p0_rvalid,
  output logic                  p1_rvalid,
  output logic [DATA_W-1:0]     rdata,
  output logic                  MemRead,
  output logic                  MemWrite,
  output logic [DM_ADDRESS-1:0] a,
  output logic [DATA_W-1:0]     wd,
  input  logic [DATA_W-1:0]     rd
);

  state_t                state, next_state;
  logic                  pick;
  logic                  take;
  logic                  sel;
  logic                  lat_we;
  logic [DM_ADDRESS-1:0] lat_addr;
  logic [DATA_W-1:0]     lat_wdata;

  assign take = (state == IDLE) && (p0_req || p1_req);

  rr_arb2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .req    ({p1_req, p0_req}),
    .update (take),
    .pick   (pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (p0_req || p1_req) next_state = ACCESS;
      ACCESS:  next_state = RESP;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // The winner's request is frozen here so later input changes cannot disturb it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel       <= PORT_CORE;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (take) begin
      sel       <= pick;
      lat_we    <= (pick == PORT_DMA) ? p1_we    : p0_we;
      lat_addr  <= (pick == PORT_DMA) ? p1_addr  : p0_addr;
      lat_wdata <= (pick == PORT_DMA) ? p1_wdata : p0_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rdata <= '0;
    else if (state == ACCESS && !lat_we)
      rdata <= rd;
  end

  always_comb begin
    p0_gnt    = 1'b0;
    p1_gnt    = 1'b0;
    p0_rvalid = 1'b0;
    p1_rvalid = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    a         = '0;
    wd        = '0;
    case (state)
      ACCESS: begin
        p0_gnt   = (sel == PORT_CORE);
        p1_gnt   = (sel == PORT_DMA);
        MemRead  = !lat_we;
        MemWrite = lat_we;
        a        = lat_addr;
        wd       = lat_we ? lat_wdata : '0;
      end
      RESP: begin
        p0_rvalid = (sel == PORT_CORE);
        p1_rvalid = (sel == PORT_DMA);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: directed scenarios then random traffic, checked each
// cycle against a transaction-level model with its own copy of memory.
module tb_dmem_arbiter;

  localparam int AW = 9;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p0_req, p0_we, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr, a;
  logic [DW-1:0] p0_wdata, p1_wdata, rdata, wd, rd;
  logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, MemRead, MemWrite;

  logic [DW-1:0] mem     [0:511];
  logic [DW-1:0] ref_mem [0:511];

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  // Model: phase counts cycles since a request was accepted (0 = free).
  int            phase, owner, last_port;
  bit            m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rdata;

  int gnt_log[$];
  int gnt_cyc[$];

  always #5 clk = ~clk;

  assign rd = mem[a];
  always @(posedge clk) if (MemWrite) mem[a] = wd;

  dmem_arbiter #(.DM_ADDRESS(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
    .rdata(rdata), .MemRead(MemRead), .MemWrite(MemWrite), .a(a), .wd(wd), .rd(rd)
  );

  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    phase     = 0;
    owner     = 0;
    last_port = 1;
    m_we      = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_rdata   = '0;
  endtask

  task automatic modelEdge();
    if (phase == 2) begin
      phase = 0;
    end else if (phase == 1) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else      m_rdata = ref_mem[m_addr];
      phase = 2;
    end else if (p0_req || p1_req) begin
      if (p0_req && p1_req) owner = 1 - last_port;
      else                  owner = p1_req ? 1 : 0;
      last_port = owner;
      m_we    = (owner == 1) ? p1_we    : p0_we;
      m_addr  = (owner == 1) ? p1_addr  : p0_addr;
      m_wdata = (owner == 1) ? p1_wdata : p0_wdata;
      phase   = 1;
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    cycle_no++;
    #1;
    if (p0_gnt) begin gnt_log.push_back(0); gnt_cyc.push_back(cycle_no); end
    if (p1_gnt) begin gnt_log.push_back(1); gnt_cyc.push_back(cycle_no); end
    checkOutput("p0_gnt",    p0_gnt,    (phase == 1 && owner == 0));
    checkOutput("p1_gnt",    p1_gnt,    (phase == 1 && owner == 1));
    checkOutput("p0_rvalid", p0_rvalid, (phase == 2 && owner == 0));
    checkOutput("p1_rvalid", p1_rvalid, (phase == 2 && owner == 1));
    checkOutput("MemRead",   MemRead,   (phase == 1 && !m_we));
    checkOutput("MemWrite",  MemWrite,  (phase == 1 && m_we));
    checkOutput("a",         a,         (phase == 1) ? m_addr : '0);
    checkOutput("wd",        wd,        (phase == 1 && m_we) ? m_wdata : '0);
    checkOutput("rdata",     rdata,     m_rdata);
    checkOutput("rw_mutex",  MemRead && MemWrite, 1'b0);
  endtask

  task automatic applyStimulus(input bit r0, input bit w0, input logic [AW-1:0] ad0, input logic [DW-1:0] d0,
                               input bit r1, input bit w1, input logic [AW-1:0] ad1, input logic [DW-1:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = ad0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = ad1; p1_wdata = d1;
    stepCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, '0, '0, 0, 0, '0, '0);
  endtask

  initial begin
    logic [DW-1:0] saved;
    int p1_count;

    for (int i = 0; i < 512; i++) begin
      mem[i]     = $urandom;
      ref_mem[i] = mem[i];
    end
    rst_n = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
    modelReset();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset_gnt",    {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}, '0);
    checkOutput("reset_mem_en", {MemRead, MemWrite}, '0);
    checkOutput("reset_a",      a, '0);
    checkOutput("reset_wd",     wd, '0);
    checkOutput("reset_rdata",  rdata, '0);
    rst_n = 1'b1;
    idleCycles(2);

    // Simultaneous reads straight after reset: core first, DMA three cycles later.
    gnt_log.delete(); gnt_cyc.delete();
    applyStimulus(1, 0, 9'h003, '0, 1, 0, 9'h007, '0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, '0, '0, 1, 0, 9'h007, '0);
    idleCycles(3);
    checkOutput("tie_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      checkOutput("tie_first",  gnt_log[0], 0);
      checkOutput("tie_second", gnt_log[1], 1);
      checkOutput("tie_gap",    gnt_cyc[1] - gnt_cyc[0], 3);
    end

    // Both ports request continuously for 12 cycles.
    gnt_log.delete(); gnt_cyc.delete();
    for (int i = 0; i < 12; i++)
      applyStimulus(1, 0, 9'(i), '0, 1, 0, 9'(i + 100), '0);
    idleCycles(3);
    checkOutput("rr_count", gnt_log.size(), 4);
    if (gnt_log.size() == 4)
      for (int i = 0; i < 4; i++) checkOutput("rr_order", gnt_log[i], i % 2);

    // Core write to 0x005, then DMA read back.
    applyStimulus(1, 1, 9'h005, 32'hDEADBEEF, 0, 0, '0, '0);
    checkOutput("wr_gnt", p0_gnt, 1'b1);
    checkOutput("wr_en",  MemWrite, 1'b1);
    checkOutput("wr_a",   a, 9'h005);
    idleCycles(1);
    checkOutput("wr_rvalid", p0_rvalid, 1'b1);
    idleCycles(1);
    applyStimulus(0, 0, '0, '0, 1, 0, 9'h005, '0);
    idleCycles(1);
    checkOutput("rd_rvalid", p1_rvalid, 1'b1);
    checkOutput("rd_data",   rdata, 32'hDEADBEEF);
    idleCycles(1);

    // Top address read; a following write must not disturb rdata.
    saved = ref_mem[9'h1FF];
    applyStimulus(0, 0, '0, '0, 1, 0, 9'h1FF, '0);
    checkOutput("top_a", a, 9'h1FF);
    idleCycles(1);
    checkOutput("top_rdata", rdata, saved);
    idleCycles(1);
    applyStimulus(1, 1, 9'h010, 32'hCAFEF00D, 0, 0, '0, '0);
    idleCycles(2);
    checkOutput("top_rdata_hold", rdata, saved);

    // DMA pulse while the FSM is in RESP is not sampled.
    gnt_log.delete(); gnt_cyc.delete();
    applyStimulus(1, 0, 9'h020, '0, 0, 0, '0, '0);
    idleCycles(1);
    applyStimulus(0, 0, '0, '0, 1, 0, 9'h021, '0);
    idleCycles(4);
    p1_count = 0;
    foreach (gnt_log[i]) if (gnt_log[i] == 1) p1_count++;
    checkOutput("resp_pulse_p1_gnt", p1_count, 0);

    // Reset during the ACCESS cycle of a write drops it.
    saved = mem[9'h00A];
    applyStimulus(1, 1, 9'h00A, 32'h12345678, 0, 0, '0, '0);
    checkOutput("abort_pre_we", MemWrite, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    modelReset();
    checkOutput("abort_we",    MemWrite, 1'b0);
    checkOutput("abort_gnt",   p0_gnt, 1'b0);
    checkOutput("abort_a",     a, '0);
    checkOutput("abort_rdata", rdata, '0);
    p0_req = 0; p0_we = 0;
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("abort_rvalid", {p0_rvalid, p1_rvalid}, '0);
    rst_n = 1'b1;
    checkOutput("abort_mem", mem[9'h00A], saved);
    applyStimulus(1, 0, 9'h001, '0, 1, 0, 9'h002, '0);
    checkOutput("abort_tie_p0", p0_gnt, 1'b1);
    idleCycles(3);

    // Random traffic; small address range so reads hit earlier writes.
    for (int i = 0; i < 400; i++)
      applyStimulus($urandom_range(0, 1), $urandom_range(0, 1), 9'($urandom_range(0, 31)), $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 1), 9'($urandom_range(0, 31)), $urandom);
    idleCycles(3);
    for (int i = 0; i < 32; i++) checkOutput("mem_final", mem[i], ref_mem[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
